game_flow_ctrl: RTL and testbench
=================================

// Module: game_flow_ctrl
// PURPOSE
//  Top-level game-flow FSM, directly downstream of the keyboard command decoder.
//  Consumes its one-frame start/back pulses plus a collision hit pulse from the sprite logic.
//  Tracks lives, death/respawn timing, post-respawn invulnerability and game-over hold.
//  Drives life back to the decoder and mode flags to the VGA/sprite layers. All timing is in frames.
// PARAMETERS
//  START_LIVES    3    lives loaded on game start; legal range 1..3 (life is 2 bits)
//  DEATH_FRAMES   60   frames spent in DYING before respawn; >=1
//  INVULN_FRAMES  90   frames after each respawn during which hits are ignored; 0 disables
//  GAMEOVER_HOLD  120  frames in GAMEOVER before start is accepted; >=0
//  Single down-counter, width $clog2(max(DEATH_FRAMES,GAMEOVER_HOLD)+1); separate invuln counter sized likewise
// PORTS
//  frame_clk   in   1  frame-rate clock (vsync-derived), all logic on posedge
//  Reset       in   1  asynchronous, active-high
//  start       in   1  one-frame pulse: start/resume request
//  back        in   1  one-frame pulse: back/quit request
//  hit         in   1  player collision this frame (level; sampled each frame)
//  life        out  2  remaining lives, registered
//  game_state  out  3  0=TITLE 1=PLAYING 2=DYING 3=GAMEOVER 4=PAUSED
//  playing     out  1  high iff game_state==PLAYING
//  respawn     out  1  one-frame pulse on every entry to PLAYING from TITLE/DYING/GAMEOVER
//  invuln      out  1  high while invuln counter !=0
//  game_over   out  1  high iff game_state==GAMEOVER
// BEHAVIOUR
//  Reset (async, any state): state=TITLE, life=0, timer=0, invuln cnt=0, respawn=0; all outputs registered.
//  TITLE: start -> PLAYING, life<=START_LIVES, respawn=1 next frame, invuln cnt<=INVULN_FRAMES. back, hit ignored.
//  PLAYING: priority hit > back > start.
//   - hit & !invuln & life>1 -> DYING, life<=life-1, timer<=DEATH_FRAMES.
//   - hit & !invuln & life==1 -> GAMEOVER, life<=0, timer<=GAMEOVER_HOLD.
//   - hit while invuln: ignored; back handled as if hit absent.
//   - back -> see CONFIGURATION. start ignored.
//   - Invuln cnt decrements once per frame in PLAYING only, saturates at 0.
//  DYING: timer decrements each frame; on the frame timer==1 -> PLAYING, respawn pulse,
//    invuln cnt<=INVULN_FRAMES. start/back/hit ignored; life holds.
//  GAMEOVER: timer decrements to 0 and holds. back -> TITLE (life<=0) any frame.
//   - start with timer==0 -> PLAYING as from TITLE. start with timer!=0 ignored.
//   - start & back same frame: back wins.
//  life never underflows; 1-frame latency from input pulse to state/flag change.
//  respawn is exactly one frame wide; never asserted on PAUSED->PLAYING.
// CONFIGURATION
//  GAME_PAUSE_EN defined:
//   - back in PLAYING -> PAUSED; invuln cnt frozen.
//   - PAUSED: start -> PLAYING (no respawn pulse, invuln resumes); back -> TITLE, life<=0.
//   - start & back same frame: back wins; hit ignored.
//  GAME_PAUSE_EN undefined:
//   - back in PLAYING -> TITLE, life<=0, invuln cnt<=0.
//   - PAUSED state unreachable; encoding 4 unused.
// TESTING (params 3/4/2/3 for speed)
//  Reset mid-DYING -> next edge: state=0, life=0, all flags 0, no respawn pulse.
//  start in TITLE -> frame+1: state=1, life=3, respawn=1 for one frame, invuln=1 for 2 frames.
//  hit during invuln, then hit after -> first ignored; second: state=2, life=2; after 4 frames state=1 with respawn pulse.
//  hit at life=1 -> state=3, life=0, game_over=1; start on hold frames 1..3 ignored; start after -> state=1, life=3.
//  back in PLAYING, macro off -> state=0, life=0; macro on -> state=4; start -> state=1, no respawn pulse.
//  hit & back same PLAYING frame, not invuln -> hit taken (state=2); start & back in GAMEOVER -> state=0.

Source files
------------

// File: rtl/game_flow_ctrl.sv
// game_flow_ctrl: top-level game-flow FSM fed by the keyboard command decoder
// (start/back pulses) and the sprite collision logic (hit). It tracks lives,
// death/respawn timing, post-respawn invulnerability and the game-over hold.
// All timing is counted in frames.
// Optional feature: define GAME_PAUSE_EN to enable the PAUSED state on back.
module game_flow_ctrl #(
  parameter int START_LIVES   = 3,
  parameter int DEATH_FRAMES  = 60,
  parameter int INVULN_FRAMES = 90,
  parameter int GAMEOVER_HOLD = 120
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic       start,
  input  logic       back,
  input  logic       hit,
  output logic [1:0] life,
  output logic [2:0] game_state,
  output logic       playing,
  output logic       respawn,
  output logic       invuln,
  output logic       game_over
);

  // One shared down-counter covers both the death delay and the game-over hold.
  localparam int TMAX = (DEATH_FRAMES > GAMEOVER_HOLD) ? DEATH_FRAMES : GAMEOVER_HOLD;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int IMAX = (INVULN_FRAMES > 0) ? INVULN_FRAMES : 1;
  localparam int IW   = $clog2(IMAX + 1);

  localparam logic [TW-1:0] C_DEATH = TW'(DEATH_FRAMES);
  localparam logic [TW-1:0] C_HOLD  = TW'(GAMEOVER_HOLD);
  localparam logic [TW-1:0] C_T1    = TW'(1);
  localparam logic [IW-1:0] C_INV   = IW'(INVULN_FRAMES);
  localparam logic [IW-1:0] C_I1    = IW'(1);
  localparam logic [1:0]    C_LIVES = 2'(START_LIVES);

  typedef enum logic [2:0] {
    ST_TITLE    = 3'd0,
    ST_PLAYING  = 3'd1,
    ST_DYING    = 3'd2,
    ST_GAMEOVER = 3'd3,
    ST_PAUSED   = 3'd4
  } state_t;

  state_t        r_state, w_state_nx;
  logic [1:0]    r_life, w_life_nx;
  logic [TW-1:0] r_timer, w_timer_nx;
  logic [IW-1:0] r_inv, w_inv_nx;
  logic          r_respawn, w_respawn_nx;
  logic          w_inv_act;

  assign w_inv_act = (r_inv != '0);

  // State and counter registers; asynchronous reset returns to an idle title screen.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      r_state   <= ST_TITLE;
      r_life    <= 2'd0;
      r_timer   <= '0;
      r_inv     <= '0;
      r_respawn <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_life    <= w_life_nx;
      r_timer   <= w_timer_nx;
      r_inv     <= w_inv_nx;
      r_respawn <= w_respawn_nx;
    end
  end

  // Next-state logic: holds everything by default, respawn is a single-frame strobe.
  always_comb begin
    w_state_nx   = r_state;
    w_life_nx    = r_life;
    w_timer_nx   = r_timer;
    w_inv_nx     = r_inv;
    w_respawn_nx = 1'b0;
    case (r_state)
      ST_TITLE: begin
        if (start) begin
          w_state_nx   = ST_PLAYING;
          w_life_nx    = C_LIVES;
          w_timer_nx   = '0;
          w_inv_nx     = C_INV;
          w_respawn_nx = 1'b1;
        end
      end
      ST_PLAYING: begin
        // Invulnerability only runs down while actually playing.
        w_inv_nx = w_inv_act ? (r_inv - C_I1) : '0;
        if (hit && !w_inv_act) begin
          if (r_life > 2'd1) begin
            w_state_nx = ST_DYING;
            w_life_nx  = r_life - 2'd1;
            w_timer_nx = C_DEATH;
          end else begin
            w_state_nx = ST_GAMEOVER;
            w_life_nx  = 2'd0;
            w_timer_nx = C_HOLD;
          end
        end else if (back) begin
`ifdef GAME_PAUSE_EN
          w_state_nx = ST_PAUSED;
`else
          w_state_nx = ST_TITLE;
          w_life_nx  = 2'd0;
          w_inv_nx   = '0;
`endif
        end
      end
      ST_DYING: begin
        if (r_timer <= C_T1) begin
          w_state_nx   = ST_PLAYING;
          w_timer_nx   = '0;
          w_inv_nx     = C_INV;
          w_respawn_nx = 1'b1;
        end else begin
          w_timer_nx = r_timer - C_T1;
        end
      end
      ST_GAMEOVER: begin
        if (back) begin
          w_state_nx = ST_TITLE;
          w_life_nx  = 2'd0;
          w_timer_nx = '0;
        end else if (start && (r_timer == '0)) begin
          w_state_nx   = ST_PLAYING;
          w_life_nx    = C_LIVES;
          w_inv_nx     = C_INV;
          w_respawn_nx = 1'b1;
        end else if (r_timer != '0) begin
          w_timer_nx = r_timer - C_T1;
        end
      end
`ifdef GAME_PAUSE_EN
      ST_PAUSED: begin
        // Invulnerability counter is frozen here; resuming gives no respawn strobe.
        if (back) begin
          w_state_nx = ST_TITLE;
          w_life_nx  = 2'd0;
          w_inv_nx   = '0;
        end else if (start) begin
          w_state_nx = ST_PLAYING;
        end
      end
`endif
      default: begin
        w_state_nx = ST_TITLE;
        w_life_nx  = 2'd0;
        w_timer_nx = '0;
        w_inv_nx   = '0;
      end
    endcase
  end

  assign life       = r_life;
  assign game_state = r_state;
  assign playing    = (r_state == ST_PLAYING);
  assign game_over  = (r_state == ST_GAMEOVER);
  assign respawn    = r_respawn;
  assign invuln     = w_inv_act;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// tb_game_flow_ctrl: directed scenarios plus randomized start/back/hit traffic,
// compared every frame against a frame-level behavioural model of the game rules.
module tb_game_flow_ctrl;

  localparam int P_LIVES  = 3;
  localparam int P_DEATH  = 4;
  localparam int P_INVULN = 2;
  localparam int P_HOLD   = 3;

  logic       frame_clk = 1'b0;
  logic       Reset = 1'b1;
  logic       start = 1'b0;
  logic       back = 1'b0;
  logic       hit = 1'b0;
  logic [1:0] life;
  logic [2:0] game_state;
  logic       playing, respawn, invuln, game_over;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state (plain integers, counted in frames).
  int m_st = 0, m_life = 0, m_timer = 0, m_inv = 0, m_resp = 0;

  game_flow_ctrl #(
    .START_LIVES(P_LIVES), .DEATH_FRAMES(P_DEATH),
    .INVULN_FRAMES(P_INVULN), .GAMEOVER_HOLD(P_HOLD)
  ) dut (
    .frame_clk(frame_clk), .Reset(Reset), .start(start), .back(back), .hit(hit),
    .life(life), .game_state(game_state), .playing(playing), .respawn(respawn),
    .invuln(invuln), .game_over(game_over)
  );

  always #5 frame_clk = ~frame_clk;

  task automatic chk(input string tag, input int obs, input int exp_v);
    n_checks++;
    if (obs != exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_life = 0; m_timer = 0; m_inv = 0; m_resp = 0;
  endtask

  // One frame of game rules.
  task automatic model_frame(input bit s, input bit b, input bit h);
    int was_inv;
    m_resp = 0;
    case (m_st)
      0: if (s) begin m_st = 1; m_life = P_LIVES; m_inv = P_INVULN; m_resp = 1; end
      1: begin
        was_inv = m_inv;
        if (m_inv > 0) m_inv--;
        if (h && was_inv == 0) begin
          m_life--;
          if (m_life > 0) begin m_st = 2; m_timer = P_DEATH; end
          else begin m_st = 3; m_timer = P_HOLD; end
        end else if (b) begin
`ifdef GAME_PAUSE_EN
          m_st = 4;
`else
          m_st = 0; m_life = 0; m_inv = 0;
`endif
        end
      end
      2: begin
        m_timer--;
        if (m_timer == 0) begin m_st = 1; m_inv = P_INVULN; m_resp = 1; end
      end
      3: begin
        if (b) m_st = 0;
        else if (s && m_timer == 0) begin m_st = 1; m_life = P_LIVES; m_inv = P_INVULN; m_resp = 1; end
        else if (m_timer > 0) m_timer--;
      end
      4: begin
        if (b) begin m_st = 0; m_life = 0; m_inv = 0; end
        else if (s) m_st = 1;
      end
      default: model_reset();
    endcase
  endtask

  task automatic check_all();
    chk("state", int'(game_state), m_st);
    chk("life", int'(life), m_life);
    chk("playing", int'(playing), int'(m_st == 1));
    chk("game_over", int'(game_over), int'(m_st == 3));
    chk("respawn", int'(respawn), m_resp);
    chk("invuln", int'(invuln), int'(m_inv > 0));
  endtask

  task automatic step(input bit s, input bit b, input bit h);
    @(negedge frame_clk);
    start = s; back = b; hit = h;
    @(posedge frame_clk);
    model_frame(s, b, h);
    #1;
    check_all();
  endtask

  // Asynchronous reset pulse placed mid-frame, released on a falling edge.
  task automatic pulse_reset();
    @(posedge frame_clk);
    #2;
    Reset = 1'b1;
    start = 1'b0; back = 1'b0; hit = 1'b0;
    #1;
    model_reset();
    chk("rst_async_state", int'(game_state), 0);
    check_all();
    @(posedge frame_clk);
    #1;
    chk("rst_edge_respawn", int'(respawn), 0);
    check_all();
    @(negedge frame_clk);
    Reset = 1'b0;
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge frame_clk);
    #1;
    chk("reset_state", int'(game_state), 0);
    chk("reset_life", int'(life), 0);
    check_all();
    @(negedge frame_clk);
    Reset = 1'b0;

    // Game start, hit during invulnerability, then a real hit and respawn.
    step(1, 0, 0);
    chk("start_state", int'(game_state), 1);
    chk("start_life", int'(life), 3);
    chk("start_respawn", int'(respawn), 1);
    chk("start_invuln", int'(invuln), 1);
    step(0, 0, 1);
    chk("inv_hit_ignored", int'(game_state), 1);
    chk("respawn_one_frame", int'(respawn), 0);
    chk("invuln_frame2", int'(invuln), 1);
    step(0, 0, 0);
    chk("invuln_expired", int'(invuln), 0);
    step(0, 0, 1);
    chk("hit_state", int'(game_state), 2);
    chk("hit_life", int'(life), 2);
    repeat (3) step(0, 0, 1);
    chk("dying_hold", int'(game_state), 2);
    step(0, 1, 0);
    chk("respawn_state", int'(game_state), 1);
    chk("respawn_pulse", int'(respawn), 1);

    // Hit and back together while vulnerable: hit wins.
    repeat (2) step(0, 0, 0);
    step(0, 1, 1);
    chk("hit_over_back", int'(game_state), 2);
    chk("hit_over_back_life", int'(life), 1);
    repeat (4) step(0, 0, 0);
    repeat (2) step(0, 0, 0);
    step(0, 0, 1);
    chk("last_life_state", int'(game_state), 3);
    chk("last_life_life", int'(life), 0);
    chk("last_life_go", int'(game_over), 1);
    repeat (3) begin
      step(1, 0, 0);
      chk("hold_start_ignored", int'(game_state), 3);
    end
    step(1, 0, 0);
    chk("restart_state", int'(game_state), 1);
    chk("restart_life", int'(life), 3);
    chk("restart_respawn", int'(respawn), 1);

    // Back while playing.
    step(0, 1, 0);
`ifdef GAME_PAUSE_EN
    chk("back_pause", int'(game_state), 4);
    step(0, 0, 1);
    step(1, 0, 0);
    chk("resume_state", int'(game_state), 1);
    chk("resume_no_respawn", int'(respawn), 0);
    step(0, 1, 0);
    step(0, 1, 0);
`else
    chk("back_title", int'(game_state), 0);
    chk("back_life", int'(life), 0);
`endif
    chk("back_to_title", int'(game_state), 0);

    // Run down to game over, then start and back together: back wins.
    step(1, 0, 0);
    for (int i = 0; i < 100 && m_st != 3; i++) step(0, 0, 1);
    chk("reach_gameover", int'(game_state), 3);
    repeat (4) step(0, 0, 0);
    step(1, 1, 0);
    chk("go_back_wins", int'(game_state), 0);

    // Reset while dying.
    step(1, 0, 0);
    repeat (2) step(0, 0, 0);
    step(0, 0, 1);
    chk("pre_reset_dying", int'(game_state), 2);
    step(0, 0, 0);
    pulse_reset();

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 599) == 0) pulse_reset();
      else step($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
                $urandom_range(0, 2) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
